// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding, default widths and credit rule for the pipelined ALU.
package alu_pipe_pkg;

   typedef enum bit [2:0] {
      NO_OP,
      ADD_OP,
      AND_OP,
      XOR_OP,
      MUL_OP,
      SUB_OP,
      ILL_OP,
      FLUSH_OP
   } alu_op_e;

   localparam int DEF_OP_WIDTH   = 8;
   localparam int DEF_LATENCY    = 5;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_TAG_WIDTH  = 4;

   // NOP and FLUSH never produce a result, so they never hold a FIFO slot.
   function automatic logic op_consumes_credit(input alu_op_e op);
      return (op != NO_OP) && (op != FLUSH_OP);
   endfunction

endpackage

// File: rtl/alu_pipe_fifo.sv
// Result FIFO with a registered output stage (not fall-through), flush input and
// an occupancy count that includes the output register.
module alu_pipe_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] mem_cnt;
   logic             load;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // The output register refills from storage whenever it is empty or being popped.
   assign load  = (mem_cnt != '0) && (!valid || pop);
   assign count = mem_cnt + CNT_W'(valid);

   // NOTE: storage words carry no reset; pointers and count decide which words are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         valid   <= 1'b0;
         dout    <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (load) begin
            rd_ptr <= next_ptr(rd_ptr);
            dout   <= mem[rd_ptr];
            valid  <= 1'b1;
         end else if (pop) begin
            valid <= 1'b0;
         end
         case ({push, load})
            2'b10:   mem_cnt <= mem_cnt + 1'b1;
            2'b01:   mem_cnt <= mem_cnt - 1'b1;
            default: mem_cnt <= mem_cnt;
         endcase
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Credit-controlled ALU: decode, LATENCY-stage result pipeline and output FIFO.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int OP_WIDTH   = DEF_OP_WIDTH,
   parameter int LATENCY    = DEF_LATENCY,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [OP_WIDTH-1:0]   a,
   input  logic [OP_WIDTH-1:0]   b,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*OP_WIDTH-1:0] out_result,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  out_err,
   output logic                  busy
);

   localparam int RES_W  = 2 * OP_WIDTH;
   localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 2);
   localparam logic [CRED_W-1:0] CREDIT_MAX = CRED_W'(FIFO_DEPTH);

   typedef struct packed {
      logic                 err;
      logic [TAG_WIDTH-1:0] tag;
      logic [RES_W-1:0]     res;
   } entry_t;

   alu_op_e               op_e;
   logic                  run_q;
   logic                  flush_q;
   logic [CRED_W-1:0]     credits;
   logic                  accept;
   logic                  take_credit;
   logic                  take_flush;
   logic                  pop;
   logic [OP_WIDTH:0]     sum_w;
   logic [OP_WIDTH:0]     diff_w;
   logic [RES_W-1:0]      result;
   logic                  err;
   logic [LATENCY-1:0]    stg_vld;
   entry_t                stg [LATENCY];
   entry_t                fifo_out;
   logic [CNT_W-1:0]      fifo_count;

   assign op_e = alu_op_e'(op);

   // in_ready depends only on registers: it never looks at in_valid or out_ready.
   assign in_ready    = run_q && !flush_q && (credits < CREDIT_MAX);
   assign accept      = in_valid && in_ready;
   assign take_credit = accept && op_consumes_credit(op_e);
   assign take_flush  = accept && (op_e == FLUSH_OP);
   assign pop         = out_valid && out_ready;

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};

   always_comb begin
      // NOTE: defaults come first so every path assigns result/err and no latch is inferred.
      result = '0;
      err    = 1'b0;
      case (op_e)
         ADD_OP:  result = {{(RES_W - OP_WIDTH - 1){1'b0}}, sum_w};
         AND_OP:  result = {{OP_WIDTH{1'b0}}, a & b};
         XOR_OP:  result = {{OP_WIDTH{1'b0}}, a ^ b};
         MUL_OP:  result = RES_W'(a) * RES_W'(b);
         SUB_OP:  result = {{(RES_W - OP_WIDTH - 1){1'b0}}, diff_w};
         ILL_OP:  err    = 1'b1;
         default: result = '0;
      endcase
   end

   // NOTE: state registers use <= so every flop sees pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_q   <= 1'b0;
         flush_q <= 1'b0;
         credits <= '0;
      end else begin
         run_q   <= 1'b1;
         flush_q <= take_flush;
         if (flush_q)                   credits <= '0;
         else if (take_credit && !pop)  credits <= credits + 1'b1;
         else if (!take_credit && pop)  credits <= credits - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_q) begin
         stg_vld <= '0;
      end else begin
         stg_vld[0] <= take_credit;
         for (int i = 1; i < LATENCY; i++) stg_vld[i] <= stg_vld[i-1];
      end
   end

   // Payload only matters where the matching valid bit is set.
   always_ff @(posedge clk) begin
      stg[0] <= '{err: err, tag: in_tag, res: result};
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
   end

   alu_pipe_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_q),
      .push  (stg_vld[LATENCY-1]),
      .din   (stg[LATENCY-1]),
      .pop   (pop),
      .dout  (fifo_out),
      .valid (out_valid),
      .count (fifo_count)
   );

   assign out_result = fifo_out.res;
   assign out_tag    = fifo_out.tag;
   assign out_err    = fifo_out.err;
   assign busy       = (|stg_vld) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus random traffic
// compared every cycle against an ordered-queue reference model.
`timescale 1ns/1ps
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   localparam int W  = 8;
   localparam int L  = 5;
   localparam int D  = 8;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [2:0]      op = 3'd0;
   logic [W-1:0]    a = '0;
   logic [W-1:0]    b = '0;
   logic [TW-1:0]   in_tag = '0;
   logic            in_ready;
   logic            out_valid;
   logic            out_err;
   logic            busy;
   logic [2*W-1:0]  out_result;
   logic [TW-1:0]   out_tag;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;

   alu_pipe #(.OP_WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [2*W-1:0] res;
      logic [TW-1:0]  tag;
      logic           err;
      int             rdy;   // first edge after which the result may be visible
   } exp_t;

   exp_t exp_q[$];
   bit   m_run   = 1'b0;
   bit   m_stall = 1'b0;

   function automatic logic [2*W-1:0] model_res(input logic [2:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
      int xi = int'(x);
      int yi = int'(y);
      int r;
      case (o)
         3'd1:    r = xi + yi;
         3'd2:    r = xi & yi;
         3'd3:    r = xi ^ yi;
         3'd4:    r = xi * yi;
         3'd5:    r = (xi - yi + (1 << (W + 1))) % (1 << (W + 1));
         default: r = 0;
      endcase
      return r[2*W-1:0];
   endfunction

   initial begin : compare
      bit exp_ready;
      bit head_vis;
      forever begin
         @(negedge clk);
         exp_ready = 1'b0;
         head_vis  = 1'b0;
         if (!m_run) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_result", out_result, 0);
            check("rst_out_tag", out_tag, 0);
            check("rst_out_err", out_err, 0);
            check("rst_busy", busy, 0);
         end else begin
            exp_ready = !m_stall && (exp_q.size() < D);
            head_vis  = (exp_q.size() != 0) && (edge_cnt >= exp_q[0].rdy);
            check("in_ready", in_ready, exp_ready);
            check("busy", busy, exp_q.size() != 0);
            check("out_valid", out_valid, head_vis);
            if (head_vis) begin
               check("out_result", out_result, exp_q[0].res);
               check("out_tag", out_tag, exp_q[0].tag);
               check("out_err", out_err, exp_q[0].err);
            end
         end
         // Advance the model across the coming edge.
         if (rst) begin
            exp_q.delete();
            m_stall = 1'b0;
            m_run   = 1'b0;
         end else begin
            if (head_vis && out_ready) void'(exp_q.pop_front());
            if (m_stall) begin
               exp_q.delete();
               m_stall = 1'b0;
            end else if (m_run && exp_ready && in_valid) begin
               if (op == 3'd7) m_stall = 1'b1;
               else if (op != 3'd0)
                  exp_q.push_back('{res: model_res(op, a, b), tag: in_tag,
                                    err: (op == 3'd6), rdy: edge_cnt + L + 2});
            end
            m_run = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers (enter and leave at posedge+2) ----------------
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [TW-1:0] t, output int acc);
      int tries = 0;
      in_valid = 1'b1; op = o; a = x; b = y; in_tag = t;
      acc = -1;
      while (acc < 0) begin
         @(negedge clk);
         if (in_ready) acc = edge_cnt + 1;
         else if (++tries > 50) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %0d", o);
            break;
         end
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
   endtask

   // Leaves the caller at a negedge.
   task automatic wait_valid(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 40);
      check({name, "_seen"}, out_valid, 1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int k;
      int n_acc;
      int n;
      int r;

      // Reset, then one ADD with the consumer always ready.
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      send(ADD_OP, 8'hFF, 8'h01, 4'd3, k);
      wait_valid("add");
      check("add_latency", edge_cnt - k, 6);
      check("add_result", out_result, 16'h0100);
      check("add_tag", out_tag, 3);
      check("add_err", out_err, 0);
      @(negedge clk);
      check("add_busy_after_pop", busy, 0);
      @(posedge clk);
      #2;

      // Back-to-back MUL then SUB.
      send(MUL_OP, 8'hFF, 8'hFF, 4'd1, k);
      send(SUB_OP, 8'h01, 8'h02, 4'd2, k);
      wait_valid("mul");
      check("mul_result", out_result, 16'hFE01);
      check("mul_tag", out_tag, 1);
      @(negedge clk);
      check("sub_follows", out_valid, 1);
      check("sub_result", out_result, 16'h01FF);
      check("sub_tag", out_tag, 2);
      @(posedge clk);
      #2;

      // Backpressure: credits cap the number of accepted requests.
      idle(5);
      out_ready = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 30 && n_acc < 10; c++) begin
         in_valid = 1'b1; op = ADD_OP;
         a = W'(8'h80 + n_acc); b = 8'h80; in_tag = TW'(n_acc);
         @(negedge clk);
         if (in_ready) n_acc++;
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      check("bp_accepted", n_acc, 8);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_head_result", out_result, 16'h0100);
      check("bp_head_tag", out_tag, 0);
      @(posedge clk);
      #2 out_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 40);
      check("bp_drained", busy, 0);
      check("bp_ready_back", in_ready, 1);
      @(posedge clk);
      #2;

      // Illegal opcode, then NOP.
      send(ILL_OP, 8'd5, 8'd7, 4'd9, k);
      wait_valid("ill");
      check("ill_result", out_result, 0);
      check("ill_err", out_err, 1);
      check("ill_tag", out_tag, 9);
      @(posedge clk);
      #2;
      idle(2);
      send(NO_OP, 8'd3, 8'd4, 4'd6, k);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("nop_no_result", out_valid, 0);
         check("nop_no_credit", busy, 0);
      end
      @(posedge clk);
      #2;

      // Flush with three ADDs in flight.
      send(ADD_OP, 8'd1, 8'd1, 4'd1, k);
      send(ADD_OP, 8'd2, 8'd2, 4'd2, k);
      send(ADD_OP, 8'd3, 8'd3, 4'd3, k);
      send(FLUSH_OP, 8'd0, 8'd0, 4'd0, k);
      @(negedge clk);
      check("flush_stall", in_ready, 0);
      @(negedge clk);
      check("flush_ready_back", in_ready, 1);
      check("flush_busy", busy, 0);
      check("flush_no_result", out_valid, 0);
      @(posedge clk);
      #2;
      send(ADD_OP, 8'd10, 8'd20, 4'd5, k);
      wait_valid("post_flush");
      check("post_flush_latency", edge_cnt - k, 6);
      check("post_flush_result", out_result, 16'd30);
      @(posedge clk);
      #2;

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 15);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case (r)
            0:       op = FLUSH_OP;
            1:       op = NO_OP;
            2:       op = ILL_OP;
            default: op = 3'(1 + (r % 5));
         endcase
         a = W'($urandom); b = W'($urandom); in_tag = TW'($urandom);
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      idle(30);

      // Reset while four results sit in the FIFO.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(ADD_OP, W'(i), 8'd1, TW'(i), k);
      idle(12);
      @(negedge clk);
      check("pre_rst_valid", out_valid, 1);
      check("pre_rst_busy", busy, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_result", out_result, 0);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("post_rst_no_stale", out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
